// File: rtl/div_sqrt_iter_seq_mvp.sv
// div_sqrt_iter_seq_mvp: sequential non-restoring mantissa divide / square-root engine
module div_sqrt_iter_seq_mvp #(
    parameter int WIDTH          = 25,
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic             Clk_CI,
    input  logic             Rst_RBI,
    input  logic             Start_SI,
    input  logic             Div_SI,
    input  logic             Kill_SI,
    input  logic [WIDTH-1:0] A_DI,
    input  logic [WIDTH-1:0] B_DI,
    output logic             Ready_SO,
    output logic             Done_SO,
    output logic [WIDTH-1:0] Result_DO,
    output logic             Sticky_SO
);
    localparam int N    = (WIDTH + ITER_PER_CYCLE - 1) / ITER_PER_CYCLE;
    localparam int LAST = WIDTH - (N - 1) * ITER_PER_CYCLE;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int RW   = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic               div_q;
    logic               accept;
    logic [RW-1:0]      rem_q, rem_half, rem_fix;
    logic [WIDTH-1:0]   quo_q, dvs_q;
    logic [2*WIDTH-1:0] rad_q;

    for (genvar c = 0; c < ITER_PER_CYCLE; c++) begin : g_cell
        localparam bit LIVE = (c < LAST);
        logic [RW-1:0]      rem_i, rem_o, base, opnd, sum;
        logic [WIDTH-1:0]   quo_i, quo_o;
        logic [2*WIDTH-1:0] rad_i, rad_o;
        logic               pos, act;
        if (c == 0) begin : g_first
            assign rem_i = rem_q;
            assign quo_i = quo_q;
            assign rad_i = rad_q;
        end else begin : g_next
            assign rem_i = g_cell[c-1].rem_o;
            assign quo_i = g_cell[c-1].quo_o;
            assign rad_i = g_cell[c-1].rad_o;
        end
        // One iteration: the divide remainder is kept pre-doubled; sqrt brings in the next radicand pair
        always_comb begin
            pos   = ~rem_i[RW-1];
            act   = LIVE || (cnt_q != '0);
            opnd  = div_q ? RW'(dvs_q) : {quo_i, ~pos, 1'b1};
            base  = div_q ? rem_i : {rem_i[RW-3:0], rad_i[2*WIDTH-1 -: 2]};
            sum   = pos ? base - opnd : base + opnd;
            rem_o = act ? (div_q ? {sum[RW-2:0], 1'b0} : sum) : rem_i;
            quo_o = act ? {quo_i[WIDTH-2:0], ~sum[RW-1]} : quo_i;
            rad_o = act ? {rad_i[2*WIDTH-3:0], 2'b00} : rad_i;
        end
    end

    // Restore a negative final remainder so the sticky bit reflects the true remainder
    always_comb begin
        rem_half = {rem_q[RW-1], rem_q[RW-1:1]};
        rem_fix  = div_q ? (rem_half[RW-1] ? rem_half + RW'(dvs_q) : rem_half)
                         : (rem_q[RW-1] ? rem_q + {1'b0, quo_q, 1'b1} : rem_q);
    end

    // State register
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = (state_q == IDLE) ? (accept ? BUSY : IDLE)
                : (state_q == BUSY) ? (Kill_SI ? IDLE : (cnt_q == '0) ? FIN : BUSY)
                : IDLE;
    end

    // Outputs: the Done cycle is not ready so a Start there is dropped
    always_comb begin
        Ready_SO = (state_q == IDLE) && !Done_SO;
        accept   = Ready_SO && Start_SI && !Kill_SI;
    end

    // Operand capture, iteration registers and result/sticky/done registers
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            cnt_q     <= '0;
            div_q     <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rad_q     <= '0;
            Done_SO   <= 1'b0;
            Result_DO <= '0;
            Sticky_SO <= 1'b0;
        end else begin
            Done_SO <= (state_q == FIN) && !Kill_SI;
            if (accept) begin
                cnt_q <= CW'(N - 1);
                div_q <= Div_SI;
                dvs_q <= B_DI;
                rem_q <= Div_SI ? RW'(A_DI) : '0;
                quo_q <= '0;
                rad_q <= {1'b0, A_DI, {(WIDTH-1){1'b0}}};
            end else if (state_q == BUSY) begin
                cnt_q <= (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
                rem_q <= g_cell[ITER_PER_CYCLE-1].rem_o;
                quo_q <= g_cell[ITER_PER_CYCLE-1].quo_o;
                rad_q <= g_cell[ITER_PER_CYCLE-1].rad_o;
            end else if (state_q == FIN && !Kill_SI) begin
                Result_DO <= quo_q;
                Sticky_SO <= |rem_fix;
            end
        end
    end
endmodule
